// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and IDLE/RUN/STALL/HALT fetch sequencer for the instruction ROM
// Optional retired-instruction counter (retired_cnt) enabled by defining FETCH_CNT_EN.
module fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          MEM_WORDS = 65,
   parameter logic [5:0]  OP_BEQ    = 6'b110000,
   parameter logic [5:0]  OP_JUMP   = 6'b110010,
   parameter logic [5:0]  OP_HALT   = 6'b111111
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        restart,
   input  logic        stall,
   input  logic        br_eq,
   input  logic [31:0] instr_in,
   output logic [31:0] imem_addr,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic        running,
   output logic        halted,
`ifdef FETCH_CNT_EN
   output logic [31:0] retired_cnt,
`endif
   output logic        fault
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_HALT} state_t;

   // 33-bit limit so a ROM spanning the whole 32-bit space cannot overflow the compare
   localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt, pc4, br_off;
   logic [5:0]  opcode;
   logic        fault_nxt, in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         fault <= fault_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      fault_nxt   = fault;
      instr_valid = 1'b0;
      opcode      = instr_in[31:26];
      pc4         = pc + 32'd4;
      br_off      = {{14{instr_in[15]}}, instr_in[15:0], 2'b00};
      in_range    = {1'b0, pc} < PC_LIMIT;
      if (restart) begin
         state_nxt = S_IDLE;
         pc_nxt    = RESET_PC;
         fault_nxt = 1'b0;
      end else begin
         case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN: begin
               if (stall) begin
                  state_nxt = S_STALL;
               end else if (!in_range) begin
                  fault_nxt = 1'b1;
                  state_nxt = S_HALT;
               end else begin
                  instr_valid = 1'b1;
                  // halt is retired but leaves PC pointing at itself
                  if (opcode == OP_HALT)
                     state_nxt = S_HALT;
                  else if (opcode == OP_BEQ)
                     pc_nxt = br_eq ? pc4 + br_off : pc4;
                  else if (opcode == OP_JUMP)
                     pc_nxt = {pc4[31:28], instr_in[25:0], 2'b00};
                  else
                     pc_nxt = pc4;
               end
            end
            S_STALL: if (!stall) state_nxt = S_RUN;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   assign imem_addr = pc;
   assign instr_out = instr_in;
   assign running   = (state == S_RUN) || (state == S_STALL);
   assign halted    = (state == S_HALT);

`ifdef FETCH_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired_cnt <= 32'd0;
      else if (restart)
         retired_cnt <= 32'd0;
      else if (instr_valid)
         retired_cnt <= retired_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
// Covers FETCH_CNT_EN counter checks when the macro is defined.
module tb_fetch_sequencer;

   localparam logic [31:0] ALU  = 32'h0000_0001;
   localparam logic [31:0] HALT = 32'hFC00_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, restart = 1'b0, stall = 1'b0, br_eq = 1'b0;
   logic [31:0] instr_in, imem_addr, instr_out;
   logic        instr_valid, running, halted, fault;
   logic        start_s = 1'b0, restart_s = 1'b0;
   logic [31:0] imem_addr_s, instr_out_s;
   logic        instr_valid_s, running_s, halted_s, fault_s;
`ifdef FETCH_CNT_EN
   logic [31:0] retired_cnt, retired_cnt_s;
`endif

   logic [31:0] rom [0:69];
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   assign instr_in = (imem_addr[31:2] < 30'd70) ? rom[imem_addr[8:2]] : 32'h0;

   fetch_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .restart(restart), .stall(stall),
      .br_eq(br_eq), .instr_in(instr_in), .imem_addr(imem_addr), .instr_out(instr_out),
      .instr_valid(instr_valid), .running(running), .halted(halted),
`ifdef FETCH_CNT_EN
      .retired_cnt(retired_cnt),
`endif
      .fault(fault)
   );

   fetch_sequencer #(.MEM_WORDS(4)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_s), .restart(restart_s), .stall(1'b0),
      .br_eq(1'b0), .instr_in(32'h0), .imem_addr(imem_addr_s), .instr_out(instr_out_s),
      .instr_valid(instr_valid_s), .running(running_s), .halted(halted_s),
`ifdef FETCH_CNT_EN
      .retired_cnt(retired_cnt_s),
`endif
      .fault(fault_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic load_rom(input int n_alu, input logic [31:0] last);
      for (int i = 0; i < 70; i++) rom[i] = 32'h0;
      for (int i = 0; i < n_alu; i++) rom[i] = ALU;
      rom[n_alu] = last;
   endtask

   task automatic do_restart();
      restart = 1'b1;
      step();
      restart = 1'b0;
      #1;
      check("restart_addr", imem_addr, 32'd0);
      check("restart_running", {31'd0, running}, 32'd0);
      check("restart_halted", {31'd0, halted}, 32'd0);
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      load_rom(3, HALT);
      #3;
      check("rst_addr", imem_addr, 32'd0);
      check("rst_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_running", {31'd0, running}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fault", {31'd0, fault}, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      check("idle_valid", {31'd0, instr_valid}, 32'd0);

      // straight-line code ending in halt
      do_start();
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t1_addr", imem_addr, 32'(4 * i));
         check("t1_valid", {31'd0, instr_valid}, 32'd1);
         step();
      end
      #1;
      check("t1_halted", {31'd0, halted}, 32'd1);
      check("t1_hold", imem_addr, 32'd12);
      check("t1_valid_off", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_CNT_EN
      check("t1_cnt", retired_cnt, 32'd4);
`endif
      start = 1'b1;
      step();
      start = 1'b0;
      #1;
      check("t1_start_ignored", {31'd0, halted}, 32'd1);
      check("t1_hold2", imem_addr, 32'd12);

      // beq backwards taken, then not taken
      do_restart();
      load_rom(3, 32'hC000_FFFE);
      rom[4] = HALT;
      do_start();
      begin
         logic [31:0] exp_pc [0:6] = '{0, 4, 8, 12, 8, 12, 16};
         logic        eq_seq [0:6] = '{0, 0, 0, 1, 0, 0, 0};
         for (int i = 0; i < 7; i++) begin
            br_eq = eq_seq[i];
            #1;
            check("t2_addr", imem_addr, exp_pc[i]);
            check("t2_valid", {31'd0, instr_valid}, 32'd1);
            step();
         end
      end
      br_eq = 1'b0;
      #1;
      check("t2_halted", {31'd0, halted}, 32'd1);
      check("t2_hold", imem_addr, 32'd16);
`ifdef FETCH_CNT_EN
      check("t2_cnt", retired_cnt, 32'd7);
`endif

      // jump loop back to 0, then stall at PC=8
      do_restart();
      load_rom(5, 32'hC800_0000);
      do_start();
      begin
         logic [31:0] exp_pc [0:7] = '{0, 4, 8, 12, 16, 20, 0, 4};
         for (int i = 0; i < 8; i++) begin
            #1;
            check("t3_addr", imem_addr, exp_pc[i]);
            check("t3_valid", {31'd0, instr_valid}, 32'd1);
            step();
         end
      end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t4_stall_addr", imem_addr, 32'd8);
         check("t4_stall_valid", {31'd0, instr_valid}, 32'd0);
         check("t4_stall_running", {31'd0, running}, 32'd1);
         step();
      end
      stall = 1'b0;
      #1;
      check("t4_release_valid", {31'd0, instr_valid}, 32'd0);
      step();
      #1;
      check("t4_resume_addr", imem_addr, 32'd8);
      check("t4_resume_valid", {31'd0, instr_valid}, 32'd1);
      step();
      #1;
      check("t4_next_addr", imem_addr, 32'd12);
      do_restart();

      // out-of-range fetch on a 4-word ROM
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t5_addr", imem_addr_s, 32'(4 * i));
         check("t5_valid", {31'd0, instr_valid_s}, 32'd1);
         step();
      end
      #1;
      check("t5_oor_addr", imem_addr_s, 32'd16);
      check("t5_oor_valid", {31'd0, instr_valid_s}, 32'd0);
      step();
      #1;
      check("t5_fault", {31'd0, fault_s}, 32'd1);
      check("t5_halted", {31'd0, halted_s}, 32'd1);
      check("t5_hold", imem_addr_s, 32'd16);
      restart_s = 1'b1;
      step();
      restart_s = 1'b0;
      #1;
      check("t5_fault_clr", {31'd0, fault_s}, 32'd0);
      check("t5_addr_clr", imem_addr_s, 32'd0);

      // asynchronous reset mid-run
      load_rom(9, HALT);
      do_start();
      for (int i = 0; i < 6; i++) step();
      #1;
      check("t6_addr", imem_addr, 32'd24);
      check("t6_valid", {31'd0, instr_valid}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_addr", imem_addr, 32'd0);
      check("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
      check("t6_rst_running", {31'd0, running}, 32'd0);
      check("t6_rst_halted", {31'd0, halted}, 32'd0);
`ifdef FETCH_CNT_EN
      check("t6_rst_cnt", retired_cnt, 32'd0);
`endif
      step();
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
